// File: rtl/io_bus_master.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | io_bus_master: RV32I load/store to SETUP/HOLD IO bus cycle sequencer      |
// | Rev 1.0 -- define IO_BUS_ALIGN_CHECK_EN to reject misaligned accesses     |
// +---------------------------------------------------------------------------+
module io_bus_master #(
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        stall,
  output logic        BC,
  output logic [31:0] addr,
  output logic [3:0]  ctrl,
  inout  wire  [31:0] data
);

  typedef enum logic [1:0] {IDLE, SETUP, HOLD, DONE} state_t;

  localparam logic [3:0] HOLD_LAST = 4'(WAIT_CYCLES - 1);

  state_t      state, state_nxt;
  logic [3:0]  cnt;
  logic        we_r;
  logic [2:0]  f3_r;
  logic [31:0] addr_r;
  logic [31:0] wdata_r;
  logic [31:0] rdata_r;
  logic        bus_active;
  logic        hold_last;
  logic        misalign;

  // Reserved funct3 encodings with [1:0]=11 fall back to word size.
  function automatic logic [1:0] size_of(input logic [2:0] f3);
    size_of = (f3[1:0] == 2'b11) ? 2'b10 : f3[1:0];
  endfunction

  function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] w);
    case (size_of(f3))
      2'b00:   store_lanes = {4{w[7:0]}};
      2'b01:   store_lanes = {2{w[15:0]}};
      default: store_lanes = w;
    endcase
  endfunction

  function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] lane,
                                           input logic [31:0] bus);
    logic [7:0]  b;
    logic [15:0] h;
    b = bus[{lane, 3'b000} +: 8];
    h = lane[1] ? bus[31:16] : bus[15:0];
    case (f3)
      3'b000:  load_ext = {{24{b[7]}}, b};
      3'b001:  load_ext = {{16{h[15]}}, h};
      3'b100:  load_ext = {24'h0, b};
      3'b101:  load_ext = {16'h0, h};
      default: load_ext = bus;
    endcase
  endfunction

`ifdef IO_BUS_ALIGN_CHECK_EN
  logic err_r;

  assign misalign = ((size_of(req_funct3) == 2'b01) && req_addr[0]) ||
                    ((size_of(req_funct3) == 2'b10) && (req_addr[1:0] != 2'b00));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      err_r <= 1'b0;
    else if (state == IDLE && req_valid)
      err_r <= misalign;
  end

  assign resp_err = (state == DONE) && err_r;
`else
  assign misalign = 1'b0;
  assign resp_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid) state_nxt = misalign ? DONE : SETUP;
      SETUP:   state_nxt = HOLD;
      HOLD:    if (hold_last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign hold_last  = (cnt == HOLD_LAST);
  assign bus_active = (state == SETUP) || (state == HOLD);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      we_r    <= 1'b0;
      f3_r    <= '0;
      addr_r  <= '0;
      wdata_r <= '0;
      rdata_r <= '0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          we_r    <= req_we;
          f3_r    <= req_funct3;
          addr_r  <= req_addr;
          wdata_r <= req_wdata;
        end
        SETUP: cnt <= '0;
        HOLD: begin
          cnt <= cnt + 4'd1;
          if (hold_last && !we_r)
            rdata_r <= load_ext(f3_r, addr_r[1:0], data);
        end
        default: cnt <= '0;
      endcase
    end
  end

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == DONE);
  assign resp_rdata = rdata_r;
  assign stall      = !rst && ((req_valid && state == IDLE) || bus_active);
  assign BC         = bus_active;
  assign addr       = bus_active ? addr_r : '0;
  assign ctrl       = bus_active ? {size_of(f3_r), we_r, !we_r} : '0;
  assign data       = (bus_active && we_r) ? store_lanes(f3_r, wdata_r) : 'z;

endmodule
`default_nettype wire

// File: tb/tb_io_bus_master.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_io_bus_master: directed vector bench for io_bus_master                 |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
module tb_io_bus_master;

  localparam int W = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        req_ready, resp_valid, resp_err, stall, BC;
  logic [31:0] resp_rdata, addr;
  logic [3:0]  ctrl;
  wire  [31:0] data;
  logic        tb_drive;
  logic [31:0] tb_bus;

  int n_cmp  = 0;
  int n_fail = 0;

  assign data = tb_drive ? tb_bus : 'z;

  io_bus_master #(.WAIT_CYCLES(W)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .stall(stall), .BC(BC), .addr(addr), .ctrl(ctrl),
    .data(data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] bus;
    logic [3:0]  ctrl;
    logic [31:0] lanes;
    logic [31:0] rdata;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", nm, act, exp);
    end
  endtask

  function automatic logic is_hiz(input logic [31:0] v);
    is_hiz = (v === 32'hzzzzzzzz) || (v === 32'h0);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    req_valid = 1'b1; req_we = v.we; req_funct3 = v.f3;
    req_addr = v.addr; req_wdata = v.wdata;
    tb_drive = !v.we; tb_bus = v.bus;
    #1;
    chk($sformatf("v%0d_c0_ready", idx), {31'b0, req_ready}, 32'd1);
    chk($sformatf("v%0d_c0_stall", idx), {31'b0, stall}, 32'd1);
    chk($sformatf("v%0d_c0_bc", idx), {31'b0, BC}, 32'd0);
    tick();
    req_valid = 1'b0;
    #1;
    chk($sformatf("v%0d_setup_bc", idx), {31'b0, BC}, 32'd1);
    chk($sformatf("v%0d_setup_ctrl", idx), {28'b0, ctrl}, {28'b0, v.ctrl});
    chk($sformatf("v%0d_setup_addr", idx), addr, v.addr);
    chk($sformatf("v%0d_setup_stall", idx), {31'b0, stall}, 32'd1);
    if (v.we) chk($sformatf("v%0d_setup_data", idx), data, v.lanes);
    for (int i = 0; i < W; i++) begin
      tick();
      chk($sformatf("v%0d_hold%0d_bc", idx, i), {31'b0, BC}, 32'd1);
      chk($sformatf("v%0d_hold%0d_ctrl", idx, i), {28'b0, ctrl}, {28'b0, v.ctrl});
      chk($sformatf("v%0d_hold%0d_addr", idx, i), addr, v.addr);
      chk($sformatf("v%0d_hold%0d_rv", idx, i), {31'b0, resp_valid}, 32'd0);
      if (v.we) chk($sformatf("v%0d_hold%0d_data", idx, i), data, v.lanes);
    end
    tick();
    chk($sformatf("v%0d_done_rv", idx), {31'b0, resp_valid}, 32'd1);
    chk($sformatf("v%0d_done_stall", idx), {31'b0, stall}, 32'd0);
    chk($sformatf("v%0d_done_ready", idx), {31'b0, req_ready}, 32'd0);
    chk($sformatf("v%0d_done_bus", idx), {27'b0, BC, ctrl}, 32'd0);
    chk($sformatf("v%0d_done_addr", idx), addr, 32'd0);
    chk($sformatf("v%0d_done_err", idx), {31'b0, resp_err}, 32'd0);
    chk($sformatf("v%0d_done_rdata", idx), resp_rdata, v.rdata);
    if (v.we) chk($sformatf("v%0d_done_hiz", idx), {31'b0, is_hiz(data)}, 32'd1);
    tb_drive = 1'b0;
    tick();
    chk($sformatf("v%0d_idle_rv", idx), {31'b0, resp_valid}, 32'd0);
    chk($sformatf("v%0d_idle_rdata", idx), resp_rdata, v.rdata);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic seen;
    //          we    f3      addr          wdata         bus           ctrl     lanes         rdata
    vecs[0]  = '{1'b0, 3'b010, 32'h00001000, 32'h0,        32'hDEADBEEF, 4'b1001, 32'h0,        32'hDEADBEEF};
    vecs[1]  = '{1'b0, 3'b000, 32'hFFFFF001, 32'h0,        32'h00008000, 4'b0001, 32'h0,        32'hFFFFFF80};
    vecs[2]  = '{1'b0, 3'b100, 32'hFFFFF001, 32'h0,        32'h00008000, 4'b0001, 32'h0,        32'h00000080};
    vecs[3]  = '{1'b1, 3'b000, 32'hFFFFF060, 32'h000000AB, 32'h0,        4'b0010, 32'hABABABAB, 32'h00000080};
    vecs[4]  = '{1'b0, 3'b001, 32'h00002002, 32'h0,        32'h80011234, 4'b0101, 32'h0,        32'hFFFF8001};
    vecs[5]  = '{1'b0, 3'b101, 32'h00002002, 32'h0,        32'h80011234, 4'b0101, 32'h0,        32'h00008001};
    vecs[6]  = '{1'b1, 3'b001, 32'h00003000, 32'h1234BEEF, 32'h0,        4'b0110, 32'hBEEFBEEF, 32'h00008001};
    vecs[7]  = '{1'b1, 3'b010, 32'h00004004, 32'hCAFEF00D, 32'h0,        4'b1010, 32'hCAFEF00D, 32'h00008001};
    vecs[8]  = '{1'b0, 3'b000, 32'h00005003, 32'h0,        32'h7F000000, 4'b0001, 32'h0,        32'h0000007F};
    vecs[9]  = '{1'b0, 3'b011, 32'h00006000, 32'h0,        32'h11223344, 4'b1001, 32'h0,        32'h11223344};
    vecs[10] = '{1'b1, 3'b111, 32'h00007000, 32'h55AA55AA, 32'h0,        4'b1010, 32'h55AA55AA, 32'h11223344};
    vecs[11] = '{1'b0, 3'b100, 32'h00008002, 32'h0,        32'h00FF0000, 4'b0001, 32'h0,        32'h000000FF};

    rst = 1'b1; req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010;
    req_addr = 32'h1000; req_wdata = 32'h0; tb_drive = 1'b0; tb_bus = 32'h0;
    tick();
    chk("rst_bc_ctrl", {27'b0, BC, ctrl}, 32'd0);
    chk("rst_addr", addr, 32'd0);
    chk("rst_resp", {30'b0, resp_valid, resp_err}, 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_stall", {31'b0, stall}, 32'd0);
    chk("rst_hiz", {31'b0, is_hiz(data)}, 32'd1);
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

    // Reset lands in the second HOLD cycle of a word store.
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
    req_addr = 32'h00009000; req_wdata = 32'h12345678;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    chk("abort_pre_bc", {31'b0, BC}, 32'd1);
    chk("abort_pre_data", data, 32'h12345678);
    #2 rst = 1'b1;
    #1;
    chk("abort_bc_ctrl", {27'b0, BC, ctrl}, 32'd0);
    chk("abort_addr", addr, 32'd0);
    chk("abort_hiz", {31'b0, is_hiz(data)}, 32'd1);
    chk("abort_rdata", resp_rdata, 32'd0);
    chk("abort_stall", {31'b0, stall}, 32'd0);
    #2 rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (resp_valid || BC) seen = 1'b1;
    end
    chk("abort_no_resp", {31'b0, seen}, 32'd0);

    // req_valid held through DONE: one IDLE cycle, then the next SETUP.
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010;
    req_addr = 32'h00001000; tb_drive = 1'b1; tb_bus = 32'hA5A5A5A5;
    tick();
    for (int i = 0; i < W + 1; i++) tick();
    chk("b2b_done_rv", {31'b0, resp_valid}, 32'd1);
    chk("b2b_done_ready", {31'b0, req_ready}, 32'd0);
    chk("b2b_done_stall", {31'b0, stall}, 32'd0);
    chk("b2b_done_rdata", resp_rdata, 32'hA5A5A5A5);
    tick();
    chk("b2b_idle_ready", {31'b0, req_ready}, 32'd1);
    chk("b2b_idle_bc", {31'b0, BC}, 32'd0);
    chk("b2b_idle_stall", {31'b0, stall}, 32'd1);
    tick();
    req_valid = 1'b0;
    #1;
    chk("b2b_setup_bc", {31'b0, BC}, 32'd1);
    chk("b2b_setup_ctrl", {28'b0, ctrl}, 32'h9);
    for (int i = 0; i < W + 1; i++) tick();
    chk("b2b_second_rv", {31'b0, resp_valid}, 32'd1);
    tick();
    tb_drive = 1'b0;

    // Misaligned word load.
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010;
    req_addr = 32'h00001002; tb_drive = 1'b1; tb_bus = 32'h0BADF00D;
    #1;
    chk("mis_c0_ctrl", {28'b0, ctrl}, 32'd0);
    tick();
    req_valid = 1'b0;
`ifdef IO_BUS_ALIGN_CHECK_EN
    #1;
    chk("mis_c1_rv", {31'b0, resp_valid}, 32'd1);
    chk("mis_c1_err", {31'b0, resp_err}, 32'd1);
    chk("mis_c1_bus", {27'b0, BC, ctrl}, 32'd0);
    chk("mis_c1_rdata", resp_rdata, 32'hA5A5A5A5);
    tick();
    chk("mis_c2_resp", {30'b0, resp_valid, resp_err}, 32'd0);
    chk("mis_c2_ctrl", {28'b0, ctrl}, 32'd0);
`else
    #1;
    chk("mis_c1_bc", {31'b0, BC}, 32'd1);
    chk("mis_c1_ctrl", {28'b0, ctrl}, 32'h9);
    for (int i = 0; i < W + 1; i++) tick();
    chk("mis_done_rv", {31'b0, resp_valid}, 32'd1);
    chk("mis_done_err", {31'b0, resp_err}, 32'd0);
    chk("mis_done_rdata", resp_rdata, 32'h0BADF00D);
    tick();
`endif
    tb_drive = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
